// File: rtl/universal_shift_reg_if.sv
// Bus bundle for universal_shift_reg: control, serial/parallel data in, register state out.
// The master drives the controls; the slave (the shift register) drives the state.
interface universal_shift_reg_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH);

    logic             en;
    logic [1:0]       mode;
    logic             s_in;
    logic             s_in_l;
    logic [WIDTH-1:0] d_in;
    logic             rot;
    logic [WIDTH-1:0] q;
    logic             s_out;
    logic             s_out_l;
    logic [CNT_W-1:0] shift_cnt;
    logic             word_done;

    modport master (
        output en, mode, s_in, s_in_l, d_in, rot,
        input  q, s_out, s_out_l, shift_cnt, word_done
    );

    modport slave (
        input  en, mode, s_in, s_in_l, d_in, rot,
        output q, s_out, s_out_l, shift_cnt, word_done
    );
endinterface

// File: rtl/universal_shift_reg.sv
// Bidirectional shift register with parallel load, hold and a word-boundary counter.
// Optional feature macro: SHIFT_ROTATE_EN (rot=1 recirculates the ejected bit).
module universal_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    universal_shift_reg_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic             w_fill_r;
    logic             w_fill_l;
    logic             w_wrap;

`ifdef SHIFT_ROTATE_EN
    assign w_fill_r = bus.rot ? r_q[0]       : bus.s_in;
    assign w_fill_l = bus.rot ? r_q[WIDTH-1] : bus.s_in_l;
`else
    logic w_unused_rot;
    assign w_unused_rot = bus.rot;
    assign w_fill_r     = bus.s_in;
    assign w_fill_l     = bus.s_in_l;
`endif

    assign w_wrap = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q    <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.en) begin
                case (bus.mode)
                    2'b01: begin
                        r_q    <= {w_fill_r, r_q[WIDTH-1:1]};
                        r_cnt  <= w_wrap ? '0 : r_cnt + CNT_W'(1);
                        r_done <= w_wrap;
                    end
                    2'b10: begin
                        r_q    <= {r_q[WIDTH-2:0], w_fill_l};
                        r_cnt  <= w_wrap ? '0 : r_cnt + CNT_W'(1);
                        r_done <= w_wrap;
                    end
                    // Load restarts the word, so a wrap on this edge never reports done.
                    2'b11: begin
                        r_q   <= bus.d_in;
                        r_cnt <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.q         = r_q;
    assign bus.s_out     = r_q[0];
    assign bus.s_out_l   = r_q[WIDTH-1];
    assign bus.shift_cnt = r_cnt;
    assign bus.word_done = r_done;
endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg (WIDTH=8): behavioural model feeds a scoreboard queue.
// Works with or without SHIFT_ROTATE_EN defined.
module tb_universal_shift_reg;
    localparam int WIDTH = 8;
    localparam int CNT_W = 3;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic [CNT_W-1:0] cnt;
        logic             done;
    } exp_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    exp_t sb_q[$];

    logic [WIDTH-1:0] m_q;
    logic [CNT_W-1:0] m_cnt;
    logic             m_done;
    int               done_pulses;

    universal_shift_reg_if #(.WIDTH(WIDTH)) u_if ();

    universal_shift_reg #(.WIDTH(WIDTH)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset && u_if.en === 1'b1)
            assert (!$isunknown(u_if.mode))
            else $error("FAIL mode_x: mode=%b while en=1", u_if.mode);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle from the negedge, update the model, push expectation, compare after the edge.
    task automatic step(input logic e, input logic [1:0] m, input logic si, input logic sil,
                        input logic [WIDTH-1:0] d, input logic r);
        logic fr, fl, sh;
        exp_t got, want;
        u_if.en = e; u_if.mode = m; u_if.s_in = si; u_if.s_in_l = sil;
        u_if.d_in = d; u_if.rot = r;
        fr = si; fl = sil;
`ifdef SHIFT_ROTATE_EN
        if (r) begin fr = m_q[0]; fl = m_q[WIDTH-1]; end
`endif
        sh = 1'b0;
        m_done = 1'b0;
        if (e) begin
            case (m)
                2'b01: begin m_q = {fr, m_q[WIDTH-1:1]}; sh = 1'b1; end
                2'b10: begin m_q = {m_q[WIDTH-2:0], fl}; sh = 1'b1; end
                2'b11: begin m_q = d; m_cnt = '0; end
                default: ;
            endcase
        end
        if (sh) begin
            if (m_cnt == 3'd7) begin m_cnt = '0; m_done = 1'b1; end
            else m_cnt = m_cnt + 3'd1;
        end
        sb_q.push_back('{q: m_q, cnt: m_cnt, done: m_done});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            want = sb_q.pop_front();
            got  = '{q: u_if.q, cnt: u_if.shift_cnt, done: u_if.word_done};
            check("q", 32'(got.q), 32'(want.q));
            check("shift_cnt", 32'(got.cnt), 32'(want.cnt));
            check("word_done", 32'(got.done), 32'(want.done));
            check("s_out", 32'(u_if.s_out), 32'(want.q[0]));
            check("s_out_l", 32'(u_if.s_out_l), 32'(want.q[WIDTH-1]));
        end
        if (got.done === 1'b1) done_pulses++;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] pat;
        n_tests = 0; n_fail = 0; done_pulses = 0;
        m_q = '0; m_cnt = '0; m_done = 1'b0;
        reset = 1'b0;
        u_if.en = 1'b0; u_if.mode = 2'b00; u_if.s_in = 1'b0; u_if.s_in_l = 1'b0;
        u_if.d_in = '0; u_if.rot = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_q", 32'(u_if.q), 32'h0);
        check("rst_cnt", 32'(u_if.shift_cnt), 32'h0);
        check("rst_done", 32'(u_if.word_done), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Test 1: asynchronous reset mid-cycle with q=FF and a nonzero count
        step(1, 2'b11, 0, 0, 8'hFF, 0);
        repeat (3) step(1, 2'b01, 1, 0, 8'h00, 0);
        #2 reset = 1'b0;
        #1;
        check("arst_q", 32'(u_if.q), 32'h0);
        check("arst_cnt", 32'(u_if.shift_cnt), 32'h0);
        check("arst_done", 32'(u_if.word_done), 32'h0);
        u_if.en = 1'b1; u_if.mode = 2'b11; u_if.d_in = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        check("arst_hold_q", 32'(u_if.q), 32'h0);
        m_q = '0; m_cnt = '0;
        @(negedge clk);
        reset = 1'b1;

        // Test 2: load A5, 8 right shifts with s_in=0
        pat = 8'hA5;
        done_pulses = 0;
        step(1, 2'b11, 0, 0, 8'hA5, 0);
        for (int i = 0; i < 8; i++) begin
            check("t2_s_out", 32'(u_if.s_out), 32'(pat[i]));
            step(1, 2'b01, 0, 0, 8'h00, 0);
        end
        check("t2_q", 32'(u_if.q), 32'h00);
        check("t2_cnt", 32'(u_if.shift_cnt), 32'h0);
        check("t2_pulses", 32'(done_pulses), 32'd1);

        // Test 3: load 81, 8 left shifts with s_in_l=1
        pat = 8'b1000_0001;
        done_pulses = 0;
        step(1, 2'b11, 0, 0, 8'h81, 0);
        for (int i = 0; i < 8; i++) begin
            check("t3_s_out_l", 32'(u_if.s_out_l), 32'(pat[i]));
            step(1, 2'b10, 0, 1, 8'h00, 0);
        end
        check("t3_q", 32'(u_if.q), 32'hFF);
        check("t3_pulses", 32'(done_pulses), 32'd1);

        // Test 4: hold through en=0 and mode=00
        done_pulses = 0;
        step(1, 2'b11, 0, 0, 8'h3C, 0);
        repeat (3) step(1, 2'b01, 0, 0, 8'h00, 0);
        repeat (5) step(0, 2'b01, 1, 1, 8'hFF, 0);
        repeat (2) step(1, 2'b00, 1, 1, 8'hFF, 0);
        check("t4_q", 32'(u_if.q), 32'h07);
        check("t4_cnt", 32'(u_if.shift_cnt), 32'd3);
        check("t4_pulses", 32'(done_pulses), 32'd0);

        // Test 5: load on the would-be wrap edge suppresses word_done
        done_pulses = 0;
        step(1, 2'b11, 0, 0, 8'h00, 0);
        repeat (7) step(1, 2'b10, 1, 0, 8'h00, 0);
        step(1, 2'b11, 0, 0, 8'h11, 0);
        check("t5_q", 32'(u_if.q), 32'h11);
        check("t5_cnt", 32'(u_if.shift_cnt), 32'd0);
        check("t5_pulses", 32'(done_pulses), 32'd0);

        // Test 6: rotate request with s_in=0
        done_pulses = 0;
        step(1, 2'b11, 0, 0, 8'h96, 0);
        repeat (8) step(1, 2'b01, 0, 0, 8'h00, 1);
`ifdef SHIFT_ROTATE_EN
        check("t6_q", 32'(u_if.q), 32'h96);
`else
        check("t6_q", 32'(u_if.q), 32'h00);
`endif
        check("t6_pulses", 32'(done_pulses), 32'd1);

        // Mixed-direction wrap then random traffic against the model
        step(1, 2'b11, 0, 0, 8'h5A, 0);
        for (int i = 0; i < 8; i++) step(1, (i % 2 == 0) ? 2'b01 : 2'b10, 1, 0, 8'h00, 0);
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom), 1'($urandom),
                 8'($urandom), 1'($urandom));

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
